keypad_scan_encoder: RTL and testbench

Scans a 4x4 matrix keypad and encodes a single debounced key press into a 4-bit code with a one-cycle valid strobe. It drives a 2-bit row index that feeds `decoder_2to4`, which produces the one-hot row drive, and it reads back the 4 column lines. It encodes the one-hot column and the row index into a binary key code for downstream logic, such as the display and control FSM.

---
 rtl/keypad_scan_encoder.sv | 158 +++++++++++++++
 tb/tb_keypad_scan_encoder.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_encoder.sv
// 4x4 keypad row scanner with column debounce and key encoding.
// Emits {row, col} code plus a one-cycle valid strobe per accepted press.
module keypad_scan_encoder #(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_in,
  output logic [1:0] row_sel,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DIVW = $clog2(SCAN_DIV);
  localparam int DBW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(SCAN_DIV - 1);
  localparam logic [DBW-1:0]  DB_LAST  = DBW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_SCAN,
    S_DEBOUNCE,
    S_PRESSED,
    S_RELEASE
  } state_t;

  state_t          state, state_n;
  logic [3:0]      col_s1, col_sync;
  logic [3:0]      col_cap, cap_n;
  logic [DIVW-1:0] div_cnt, div_n;
  logic [DBW-1:0]  db_cnt, cnt_n;
  logic [1:0]      row_n;
  logic [3:0]      code_n;
  logic            valid_n, held_n;
  logic            col_ok, col_match, col_zero;

  function automatic logic [1:0] enc(input logic [3:0] c);
    case (c)
      4'b0010: enc = 2'd1;
      4'b0100: enc = 2'd2;
      4'b1000: enc = 2'd3;
      default: enc = 2'd0;
    endcase
  endfunction

  assign col_ok    = $onehot(col_sync);
  assign col_match = (col_sync == col_cap);
  assign col_zero  = (col_sync == 4'b0000);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_SCAN;
      col_s1    <= '0;
      col_sync  <= '0;
      col_cap   <= '0;
      div_cnt   <= '0;
      db_cnt    <= '0;
      row_sel   <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state     <= state_n;
      col_s1    <= col_in;
      col_sync  <= col_s1;
      col_cap   <= cap_n;
      div_cnt   <= div_n;
      db_cnt    <= cnt_n;
      row_sel   <= row_n;
      key_code  <= code_n;
      key_valid <= valid_n;
      key_held  <= held_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_SCAN: begin
        if (div_cnt == DIV_LAST && col_ok)
          state_n = S_DEBOUNCE;
      end
      S_DEBOUNCE: begin
        if (!col_match)
          state_n = S_SCAN;
        else if (db_cnt == DB_LAST)
          state_n = S_PRESSED;
      end
      S_PRESSED: begin
        if (col_zero)
          state_n = S_RELEASE;
      end
      S_RELEASE: begin
        if (!col_zero)
          state_n = S_PRESSED;
        else if (db_cnt == DB_LAST)
          state_n = S_SCAN;
      end
      default: state_n = S_SCAN;
    endcase
  end

  always_comb begin
    row_n   = row_sel;
    div_n   = div_cnt;
    cnt_n   = db_cnt;
    cap_n   = col_cap;
    code_n  = key_code;
    valid_n = 1'b0;
    held_n  = key_held;
    case (state)
      S_SCAN: begin
        if (div_cnt == DIV_LAST) begin
          div_n = '0;
          if (col_ok) begin
            cap_n = col_sync;
            cnt_n = '0;
          end else begin
            row_n = row_sel + 2'd1;
          end
        end else begin
          div_n = div_cnt + DIVW'(1);
        end
      end
      S_DEBOUNCE: begin
        if (state_n == S_PRESSED) begin
          code_n  = {row_sel, enc(col_cap)};
          valid_n = 1'b1;
          held_n  = 1'b1;
          cnt_n   = '0;
        end else if (state_n == S_SCAN) begin
          div_n = '0;
        end else begin
          cnt_n = db_cnt + DBW'(1);
        end
      end
      S_PRESSED: begin
        if (col_zero)
          cnt_n = '0;
      end
      S_RELEASE: begin
        if (state_n == S_SCAN) begin
          held_n = 1'b0;
          row_n  = row_sel + 2'd1;
          div_n  = '0;
          cnt_n  = '0;
        end else if (!col_zero) begin
          cnt_n = '0;
        end else begin
          cnt_n = db_cnt + DBW'(1);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_keypad_scan_encoder.sv
// Directed bench for keypad_scan_encoder with SCAN_DIV=8, DEBOUNCE_CYCLES=16.
// Keypad modelled as one key gated by the scanned row.
module tb_keypad_scan_encoder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] col_in;
  logic [1:0] row_sel;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic       kon  = 1'b0;
  logic [1:0] krow = 2'd0;
  logic [3:0] kcol = 4'd0;

  int n_cmp = 0;
  int n_bad = 0;

  assign col_in = (kon && row_sel == krow) ? kcol : 4'b0000;

  always #5 clk = ~clk;

  keypad_scan_encoder #(
    .SCAN_DIV(8),
    .DEBOUNCE_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .col_in(col_in),
    .row_sel(row_sel),
    .key_code(key_code),
    .key_valid(key_valid),
    .key_held(key_held)
  );

  // Leaves the bench at the negedge of the first cycle after reset.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    kon = 1'b0;
    do_reset();
    n_cmp++;
    if (row_sel !== 2'd0) begin
      n_bad++;
      $display("FAIL reset_row: got %0d want 0", row_sel);
    end
    n_cmp++;
    if (key_code !== 4'd0) begin
      n_bad++;
      $display("FAIL reset_code: got %b want 0000", key_code);
    end
    n_cmp++;
    if (key_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_valid: got %b want 0", key_valid);
    end
    n_cmp++;
    if (key_held !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_held: got %b want 0", key_held);
    end
  endtask

  task automatic test_idle_scan();
    int vcnt = 0;
    logic [1:0] exp_row;
    kon = 1'b0;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      exp_row = 2'((i / 8) % 4);
      n_cmp++;
      if (row_sel !== exp_row) begin
        n_bad++;
        $display("FAIL idle_row c%0d: got %0d want %0d",
                 i, row_sel, exp_row);
      end
      if (key_valid) vcnt++;
      @(negedge clk);
    end
    n_cmp++;
    if (vcnt != 0) begin
      n_bad++;
      $display("FAIL idle_valid: got %0d pulses want 0", vcnt);
    end
  endtask

  task automatic test_clean_press();
    int vcnt = 0;
    krow = 2'd2;
    kcol = 4'b0010;
    kon  = 1'b1;
    do_reset();
    for (int i = 0; i < 46; i++) begin
      if (key_valid) vcnt++;
      if (i == 39) begin
        n_cmp++;
        if (key_valid !== 1'b0) begin
          n_bad++;
          $display("FAIL press_early: got valid %b want 0", key_valid);
        end
      end
      if (i == 40) begin
        n_cmp++;
        if (key_valid !== 1'b1) begin
          n_bad++;
          $display("FAIL press_valid: got %b want 1", key_valid);
        end
        n_cmp++;
        if (key_code !== 4'b1001) begin
          n_bad++;
          $display("FAIL press_code: got %b want 1001", key_code);
        end
        n_cmp++;
        if (key_held !== 1'b1) begin
          n_bad++;
          $display("FAIL press_held: got %b want 1", key_held);
        end
      end
      @(negedge clk);
    end
    n_cmp++;
    if (vcnt != 1) begin
      n_bad++;
      $display("FAIL press_count: got %0d pulses want 1", vcnt);
    end
    n_cmp++;
    if (row_sel !== 2'd2) begin
      n_bad++;
      $display("FAIL press_row: got %0d want 2", row_sel);
    end
    n_cmp++;
    if (key_held !== 1'b1) begin
      n_bad++;
      $display("FAIL press_hold: got %b want 1", key_held);
    end
    kon = 1'b0;
  endtask

  task automatic test_short_bounce();
    int vcnt = 0;
    krow = 2'd1;
    kcol = 4'b1000;
    kon  = 1'b0;
    do_reset();
    for (int i = 0; i < 41; i++) begin
      if (i >= 8 && i <= 15)
        kon = 1'b1;
      else if (i >= 16 && i <= 25)
        kon = (i % 2 == 1);
      else
        kon = 1'b0;
      if (key_valid) vcnt++;
      if (i == 18 || i == 19 || i == 26) begin
        n_cmp++;
        if (row_sel !== 2'd1) begin
          n_bad++;
          $display("FAIL bounce_row c%0d: got %0d want 1", i, row_sel);
        end
      end
      if (i == 27) begin
        n_cmp++;
        if (row_sel !== 2'd2) begin
          n_bad++;
          $display("FAIL bounce_adv: got %0d want 2", row_sel);
        end
      end
      @(negedge clk);
    end
    n_cmp++;
    if (vcnt != 0) begin
      n_bad++;
      $display("FAIL bounce_valid: got %0d pulses want 0", vcnt);
    end
    kon = 1'b0;
  endtask

  task automatic test_ghost_press();
    int vcnt = 0;
    krow = 2'd0;
    kcol = 4'b0110;
    kon  = 1'b1;
    do_reset();
    for (int i = 0; i < 41; i++) begin
      if (key_valid) vcnt++;
      if (i == 8 || i == 40) begin
        n_cmp++;
        if (row_sel !== 2'd1) begin
          n_bad++;
          $display("FAIL ghost_row c%0d: got %0d want 1", i, row_sel);
        end
      end
      if (i == 32) begin
        n_cmp++;
        if (row_sel !== 2'd0) begin
          n_bad++;
          $display("FAIL ghost_wrap: got %0d want 0", row_sel);
        end
      end
      @(negedge clk);
    end
    n_cmp++;
    if (vcnt != 0) begin
      n_bad++;
      $display("FAIL ghost_valid: got %0d pulses want 0", vcnt);
    end
    kon = 1'b0;
  endtask

  task automatic test_release_bounce();
    int vcnt = 0;
    krow = 2'd3;
    kcol = 4'b0001;
    kon  = 1'b1;
    do_reset();
    for (int i = 0; i < 91; i++) begin
      kon = !((i >= 52 && i <= 56) || (i >= 60 && i <= 64) || i >= 68);
      if (key_valid) vcnt++;
      if (i == 48) begin
        n_cmp++;
        if (key_valid !== 1'b1) begin
          n_bad++;
          $display("FAIL rel_valid: got %b want 1", key_valid);
        end
        n_cmp++;
        if (key_code !== 4'b1100) begin
          n_bad++;
          $display("FAIL rel_code: got %b want 1100", key_code);
        end
      end
      if (i == 66 || i == 70 || i == 86) begin
        n_cmp++;
        if (key_held !== 1'b1) begin
          n_bad++;
          $display("FAIL rel_held c%0d: got %b want 1", i, key_held);
        end
      end
      if (i == 86) begin
        n_cmp++;
        if (row_sel !== 2'd3) begin
          n_bad++;
          $display("FAIL rel_row_hold: got %0d want 3", row_sel);
        end
      end
      if (i == 87) begin
        n_cmp++;
        if (key_held !== 1'b0) begin
          n_bad++;
          $display("FAIL rel_fall: got %b want 0", key_held);
        end
        n_cmp++;
        if (row_sel !== 2'd0) begin
          n_bad++;
          $display("FAIL rel_row_next: got %0d want 0", row_sel);
        end
      end
      @(negedge clk);
    end
    n_cmp++;
    if (vcnt != 1) begin
      n_bad++;
      $display("FAIL rel_count: got %0d pulses want 1", vcnt);
    end
    kon = 1'b0;
  endtask

  task automatic test_reset_mid();
    int v1 = 0;
    int v2 = 0;
    krow = 2'd2;
    kcol = 4'b0010;
    kon  = 1'b1;
    do_reset();
    for (int i = 0; i < 101; i++) begin
      if (i == 30 || i == 75) rst = 1'b1;
      if (i == 31 || i == 76) rst = 1'b0;
      if (i >= 31 && i <= 70 && key_valid) v1++;
      if (i >= 76 && key_valid) v2++;
      if (i == 31 || i == 76) begin
        n_cmp++;
        if (row_sel !== 2'd0) begin
          n_bad++;
          $display("FAIL rstmid_row c%0d: got %0d want 0", i, row_sel);
        end
        n_cmp++;
        if (key_code !== 4'd0) begin
          n_bad++;
          $display("FAIL rstmid_code c%0d: got %b want 0000", i, key_code);
        end
        n_cmp++;
        if (key_held !== 1'b0) begin
          n_bad++;
          $display("FAIL rstmid_held c%0d: got %b want 0", i, key_held);
        end
        n_cmp++;
        if (key_valid !== 1'b0) begin
          n_bad++;
          $display("FAIL rstmid_valid c%0d: got %b want 0", i, key_valid);
        end
      end
      if (i == 71) begin
        n_cmp++;
        if (key_valid !== 1'b1 || key_code !== 4'b1001) begin
          n_bad++;
          $display("FAIL rstmid_press: got %b/%b want 1/1001",
                   key_valid, key_code);
        end
      end
      @(negedge clk);
    end
    n_cmp++;
    if (v1 != 0) begin
      n_bad++;
      $display("FAIL rstmid_pend1: got %0d pulses want 0", v1);
    end
    n_cmp++;
    if (v2 != 0) begin
      n_bad++;
      $display("FAIL rstmid_pend2: got %0d pulses want 0", v2);
    end
    kon = 1'b0;
  endtask

  initial begin
    test_reset();
    test_idle_scan();
    test_clean_press();
    test_short_bounce();
    test_ghost_press();
    test_release_bounce();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
